bcd2bin_seq: RTL



---
 rtl/bcd2bin_pkg.sv | 39 +++
 rtl/bcd2bin_seq_sub3.sv | 17 +
 rtl/bcd2bin_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd2bin_pkg.sv
// -----------------------------------------------------------------------------
// bcd2bin_pkg
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_t        : converter FSM states (IDLE / SHIFT / DONE)
//   BIN_W          : width of the binary result (0..9999 fits in 14 bits)
//   BCD_DIGITS     : number of packed BCD digits
//   BCD_W          : width of the packed BCD word
//   N_SHIFTS       : right shifts needed to move every BCD bit into the result
//   DIGIT_MAX      : largest legal BCD digit value
//   CNT_W          : width of the shift counter
//   has_bad_digit(): true when any 4-bit digit of a packed BCD word exceeds 9
// -----------------------------------------------------------------------------
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BIN_W      = 14;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 16;
    localparam int N_SHIFTS   = 14;
    localparam int DIGIT_MAX  = 9;
    localparam int CNT_W      = 4;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'(DIGIT_MAX)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd2bin_seq_sub3.sv
// -----------------------------------------------------------------------------
// sub3
// Combinational BCD digit corrector for reverse double-dabble.
// After a right shift, a digit that received a '1' from the digit above holds
// its true value + 8 instead of + 5 (a tens-weight bit is worth 5 one position
// lower in decimal); subtracting 3 restores it. Inverse of the add-3 cell.
//   din  : 4-bit digit after the shift
//   dout : din >= 8 ? din - 3 : din
// -----------------------------------------------------------------------------
module sub3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// bcd2bin_seq
// Sequential 4-digit packed BCD to 14-bit binary converter (reverse
// double-dabble: shift {bcd,acc} right, then subtract 3 from digits >= 8).
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : request conversion, accepted in IDLE or DONE only
//   thousands, HUNDREDS, TENS, ONES : BCD digits, captured on accepted start
//   busy       : high while shifting (14 cycles per conversion)
//   done       : one-cycle pulse, bin/err valid from this cycle
//   bin        : binary result, held until the next done
//   err        : invalid-digit flag, qualified by done
// Optional feature: define BCD2BIN_CHECK_EN to reject digits > 9 with a
// single-cycle done + err (bin = 0). Without it err is constant 0 and
// illegal digits go through the normal algorithm.
// -----------------------------------------------------------------------------
module bcd2bin_seq
    import bcd2bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       thousands,
    input  logic [3:0]       HUNDREDS,
    input  logic [3:0]       TENS,
    input  logic [3:0]       ONES,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin,
    output logic             err
);

    state_t             state;
    logic [BCD_W-1:0]   bcd_r;
    logic [BIN_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   bcd_in;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bcd_corr;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   acc_shift;
    logic               bad;

    assign bcd_in = {thousands, HUNDREDS, TENS, ONES};

    // The lowest BCD bit falls into the top of the accumulator each shift.
    assign bcd_shift = {1'b0, bcd_r[BCD_W-1:1]};
    assign acc_shift = {bcd_r[0], acc_r[BIN_W-1:1]};

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            sub3 u_sub3 (
                .din  (bcd_shift[4*gi +: 4]),
                .dout (bcd_corr[4*gi +: 4])
            );
        end
    endgenerate

    // No correction after the final shift: bcd is already empty by then.
    assign bcd_next = (cnt != '0) ? bcd_corr : bcd_shift;

`ifdef BCD2BIN_CHECK_EN
    assign bad = has_bad_digit(bcd_in);
`else
    assign bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bcd_r <= '0;
            acc_r <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (bad) begin
                            // Rejected request: report immediately, no shifting.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            bin   <= '0;
                        end else begin
                            state <= SHIFT;
                            bcd_r <= bcd_in;
                            acc_r <= '0;
                            cnt   <= CNT_W'(N_SHIFTS - 1);
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here (not queued).
                    bcd_r <= bcd_next;
                    acc_r <= acc_shift;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bin   <= acc_shift;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
